rr_bus_mux: RTL and testbench

- Parametrised N-channel, WIDTH-bit arbitrated bus multiplexer with valid/ready handshakes on every input and on the output.
- Generalises the combinational 2:1/4:1 byte selectors. Selection is decided by round-robin or fixed-priority arbitration instead of explicit select lines, and the result is registered.
- Sits between multiple bus masters (PC, ALU, RAM out, immediate) and the shared 8-bit data bus or a downstream register.

---
 rtl/rr_bus_mux_pkg.sv | 19 +
 rtl/rr_bus_mux_rr_arbiter.sv | 45 ++++
 rtl/rr_bus_mux.sv | 81 ++++++++
 tb/tb_rr_bus_mux.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_bus_mux_pkg.sv
// Shared bus constants, arbitration mode encodings and helpers for rr_bus_mux.
package rr_bus_mux_pkg;

  localparam int unsigned BUS_WIDTH = 8;

  localparam bit RR_MODE    = 1'b0;
  localparam bit FIXED_MODE = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Channel-index width; a single channel still needs a 1-bit index.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_bus_mux_rr_arbiter.sv
// Combinational round-robin / fixed-priority arbiter returning a one-hot grant and its index.
module rr_arbiter
  import rr_bus_mux_pkg::*;
#(
  parameter  int unsigned CHANNELS   = 4,
  parameter  bit          FIXED_PRIO = 1'b0,
  localparam int unsigned CHAN_W     = clog2_min1(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CHAN_W-1:0]   last,
  input  logic                mode,
  output logic [CHANNELS-1:0] grant,
  output logic [CHAN_W-1:0]   grant_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (FIXED_PRIO || (mode == FIXED_MODE)) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!found && req[i]) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = CHAN_W'(i);
        end
      end
    end else begin
      // Search upward from the channel after the last winner, wrapping round.
      for (int unsigned k = 1; k <= CHANNELS; k++) begin
        idx = (32'(last) + k) % CHANNELS;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = CHAN_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/rr_bus_mux.sv
// N-channel arbitrated bus multiplexer with valid/ready handshakes and a registered output.
module rr_bus_mux
  import rr_bus_mux_pkg::*;
#(
  parameter  int unsigned WIDTH      = BUS_WIDTH,
  parameter  int unsigned CHANNELS   = 4,
  parameter  bit          FIXED_PRIO = 1'b0,
  localparam int unsigned CHAN_W     = clog2_min1(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS-1:0]       en_mask,
  output logic [WIDTH-1:0]          out_data,
  output logic [CHAN_W-1:0]         out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  out_state_e          state, state_next;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] grant;
  logic [CHAN_W-1:0]   grant_idx;
  logic [CHAN_W-1:0]   last;
  logic [WIDTH-1:0]    sel_data;
  logic                load;
  logic                xfer;

  assign req = in_valid & en_mask;

  rr_arbiter #(
    .CHANNELS   (CHANNELS),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arbiter (
    .req       (req),
    .last      (last),
    .mode      (FIXED_PRIO ? FIXED_MODE : RR_MODE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (load) state_next = xfer ? FULL : EMPTY;
  end

  // in_ready is held low while reset is asserted so nothing appears accepted.
  always_comb begin
    out_valid = (state == FULL);
    load      = !out_valid || out_ready;
    in_ready  = grant & {CHANNELS{load & rst_n}};
    xfer      = |(in_valid & in_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_chan <= '0;
      last     <= CHAN_W'(CHANNELS - 1);
    end else if (xfer) begin
      out_data <= sel_data;
      out_chan <= grant_idx;
      if (!FIXED_PRIO) last <= grant_idx;
    end
  end

endmodule

// File: tb/tb_rr_bus_mux.sv
// Directed self-checking bench for rr_bus_mux: round-robin, fixed-priority and single-channel instances.
module tb_rr_bus_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid, en_mask;
  logic        out_ready;

  logic [3:0]  in_ready, fp_in_ready;
  logic [7:0]  out_data, fp_out_data;
  logic [1:0]  out_chan, fp_out_chan;
  logic        out_valid, fp_out_valid;

  logic [7:0]  s_in_data, s_out_data;
  logic        s_in_valid, s_in_ready, s_en_mask, s_out_valid;
  logic [0:0]  s_out_chan;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_bus_mux #(.WIDTH(8), .CHANNELS(4), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .en_mask(en_mask), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready));

  rr_bus_mux #(.WIDTH(8), .CHANNELS(4), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(fp_in_ready),
    .en_mask(en_mask), .out_data(fp_out_data), .out_chan(fp_out_chan), .out_valid(fp_out_valid),
    .out_ready(out_ready));

  rr_bus_mux #(.WIDTH(8), .CHANNELS(1), .FIXED_PRIO(1'b0)) dut_one (
    .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .en_mask(s_en_mask), .out_data(s_out_data), .out_chan(s_out_chan), .out_valid(s_out_valid),
    .out_ready(out_ready));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst_n asserted with default stimulus applied.
  task automatic reset_dut();
    rst_n      = 1'b0;
    in_data    = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid   = 4'b1111;
    en_mask    = 4'b1111;
    out_ready  = 1'b1;
    s_in_data  = 8'h00;
    s_in_valid = 1'b0;
    s_en_mask  = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++;
    if ({out_valid, out_chan, out_data} !== 11'd0) begin
      n_fail++; $display("FAIL reset_out: got v=%b c=%0d d=%h, want 0/0/00", out_valid, out_chan, out_data);
    end
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, want 0000", in_ready);
    end
    n_checks++;
    if (fp_out_valid !== 1'b0 || s_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_other: got fp_v=%b s_v=%b, want 0 0", fp_out_valid, s_out_valid);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++; $display("FAIL release_in_ready: got %b, want 0001", in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_chan, out_data} !== {1'b1, 2'd0, 8'h11}) begin
      n_fail++; $display("FAIL release_first: got v=%b c=%0d d=%h, want 1/0/11", out_valid, out_chan, out_data);
    end
  endtask

  task automatic test_rr_sweep();
    logic [39:0] exp_d;
    exp_d = 40'h11_22_33_44_11;
    reset_dut();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({out_valid, out_chan, out_data} !== {1'b1, 2'(i % 4), exp_d[39-8*i -: 8]}) begin
        n_fail++;
        $display("FAIL rr_sweep[%0d]: got v=%b c=%0d d=%h, want 1/%0d/%h",
                 i, out_valid, out_chan, out_data, i % 4, exp_d[39-8*i -: 8]);
      end
    end
  endtask

  task automatic test_stall();
    reset_dut();
    rst_n = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = {8'hD0, 8'hC0, 8'hB0, 8'hA0} + {4{8'(i)}};
      en_mask = (i == 1) ? 4'b0100 : 4'b1111;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin
        n_fail++; $display("FAIL stall_in_ready[%0d]: got %b, want 0000", i, in_ready);
      end
      tick();
      n_checks++;
      if ({out_valid, out_chan, out_data} !== {1'b1, 2'd1, 8'h22}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b c=%0d d=%h, want 1/1/22", i, out_valid, out_chan, out_data);
      end
    end
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    en_mask   = 4'b1111;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, out_chan, out_data} !== {1'b1, 2'd2, 8'h33}) begin
      n_fail++; $display("FAIL stall_release: got v=%b c=%0d d=%h, want 1/2/33", out_valid, out_chan, out_data);
    end
  endtask

  task automatic test_mask_sparse();
    logic [1:0] ec;
    reset_dut();
    en_mask = 4'b1010;
    rst_n   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ec = (i % 2 == 0) ? 2'd1 : 2'd3;
      #1;
      n_checks++;
      if (in_ready !== (4'b0001 << ec)) begin
        n_fail++; $display("FAIL mask_in_ready[%0d]: got %b, want %b", i, in_ready, 4'b0001 << ec);
      end
      tick();
      n_checks++;
      if ({out_valid, out_chan, out_data} !== {1'b1, ec, (ec == 2'd1) ? 8'h22 : 8'h44}) begin
        n_fail++; $display("FAIL mask_grant[%0d]: got v=%b c=%0d d=%h, want 1/%0d", i, out_valid, out_chan, out_data, ec);
      end
    end
    en_mask  = 4'b1111;
    in_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({out_valid, out_chan, out_data, in_ready} !== {1'b1, 2'd2, 8'h33, 4'b0100}) begin
        n_fail++; $display("FAIL sparse_b2b[%0d]: got v=%b c=%0d d=%h rdy=%b, want 1/2/33/0100",
                           i, out_valid, out_chan, out_data, in_ready);
      end
    end
    in_valid = 4'b0000;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_fixed_prio();
    reset_dut();
    in_valid = 4'b1010;
    rst_n    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({fp_out_valid, fp_out_chan, fp_out_data, fp_in_ready} !== {1'b1, 2'd1, 8'h22, 4'b0010}) begin
        n_fail++; $display("FAIL fixed_low[%0d]: got v=%b c=%0d d=%h rdy=%b, want 1/1/22/0010",
                           i, fp_out_valid, fp_out_chan, fp_out_data, fp_in_ready);
      end
    end
    in_valid = 4'b1000;
    tick();
    n_checks++;
    if ({fp_out_valid, fp_out_chan, fp_out_data} !== {1'b1, 2'd3, 8'h44}) begin
      n_fail++; $display("FAIL fixed_drop: got v=%b c=%0d d=%h, want 1/3/44", fp_out_valid, fp_out_chan, fp_out_data);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if ({out_valid, out_chan} !== {1'b1, 2'd2}) begin
      n_fail++; $display("FAIL pre_async: got v=%b c=%0d, want 1/2", out_valid, out_chan);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_chan, out_data} !== 11'd0) begin
      n_fail++; $display("FAIL async_clear: got v=%b c=%0d d=%h, want 0/0/00", out_valid, out_chan, out_data);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, out_chan, out_data} !== {1'b1, 2'd0, 8'h11}) begin
      n_fail++; $display("FAIL async_restart: got v=%b c=%0d d=%h, want 1/0/11", out_valid, out_chan, out_data);
    end
  endtask

  task automatic test_single();
    reset_dut();
    rst_n      = 1'b1;
    s_in_valid = 1'b1;
    s_in_data  = 8'hA5;
    #1;
    n_checks++;
    if (s_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready: got %b, want 1", s_in_ready);
    end
    tick();
    n_checks++;
    if ({s_out_valid, s_out_chan, s_out_data} !== {1'b1, 1'b0, 8'hA5}) begin
      n_fail++; $display("FAIL single_first: got v=%b c=%0d d=%h, want 1/0/a5", s_out_valid, s_out_chan, s_out_data);
    end
    s_in_data = 8'h5A;
    tick();
    n_checks++;
    if ({s_out_valid, s_out_chan, s_out_data} !== {1'b1, 1'b0, 8'h5A}) begin
      n_fail++; $display("FAIL single_second: got v=%b c=%0d d=%h, want 1/0/5a", s_out_valid, s_out_chan, s_out_data);
    end
    s_en_mask = 1'b0;
    #1;
    n_checks++;
    if (s_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_masked_ready: got %b, want 0", s_in_ready);
    end
    tick();
    n_checks++;
    if (s_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_masked_out: got out_valid=%b, want 0", s_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_rr_sweep();
    test_stall();
    test_mask_sparse();
    test_fixed_prio();
    test_async_reset();
    test_single();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
